calc_sequencer: RTL
===================

# calc_sequencer

Entry and execution controller for the keypad calculator. It takes raw key codes from the column comparator, debounces them, and builds two signed operands of up to three decimal digits plus an operator. It then fires a one-cycle start into the arithmetic datapath, waits for its done, and holds the result view until the next entry. It sits between the keypad scan path and the operation/display blocks and replaces button-driven sequencing.

## Interface
- DEBOUNCE, 20: consecutive synchronized cycles `key_valid` must stay high before a key is accepted (20 ms at the 1 kHz clock).
- TIMEOUT, 255: cycles to wait for `alu_done` after `start` before entering ERR.
- clk  in  1  system clock (the 1 kHz divided clock).
- btnres  in  1  asynchronous, active-low reset.
- tecla  in  4  key code from the comparator: 0x0–0x9 digit; 0xA add; 0xB sub; 0xC mul; 0xD sign toggle; 0xE equals; 0xF clear.
- key_valid  in  1  high while any key is pressed; asynchronous to this block.
- alu_done  in  1  datapath result valid; sampled only in EXEC.
- start  out  1  one-cycle pulse launching the operation.
- oper  out  2  operator: 00 add, 01 sub, 10 mul.
- num1, num2  out  10  unsigned binary magnitudes, 0–999.
- sig1, sig2  out  1  operand sign, 1 = negative.
- bcd_a, bcd_b  out  12  BCD of operand A and operand B, for the display.
- state  out  3  current state encoding: ENTER_A=0, ENTER_OP=1, ENTER_B=2, EXEC=3, SHOW=4, ERR=5.
- err  out  1  high in ERR.

## Operation
- `tecla` and `key_valid` pass through a 2-FF synchronizer.
- A debounce counter counts consecutive synchronized-high cycles. It resets to 0 on any low cycle.
- On the cycle the count reaches DEBOUNCE, the block produces `acc` (an internal one-cycle accept pulse) with the synchronized `tecla`. It then disarms.
- It re-arms only after `key_valid` has been low for at least 1 synchronized cycle. This gives exactly one accept per press.
- Digit entry updates magnitude `= mag*10 + d` and BCD `= {bcd[7:0], d}`.
  - The per-operand digit counter saturates at 3; a 4th digit is ignored.
  - Leading zeros count as digits.
- ENTER_A:
  - Digit: append to A.
  - 0xD: toggle sig1.
  - 0xA/B/C: latch `oper` and go to ENTER_OP. With no digits entered, A = 0.
  - 0xE: ignored.
- ENTER_OP:
  - Another operator key: overwrites `oper`.
  - Digit: clears B, appends the digit, goes to ENTER_B.
  - 0xD: toggles sig2.
  - 0xE: B = 0, go to EXEC.
- ENTER_B:
  - Digit: append to B.
  - 0xD: toggle sig2.
  - 0xE: go to EXEC.
  - Operator keys: ignored (no chaining).
- EXEC:
  - Assert `start` on the first cycle only.
  - Operands and `oper` are frozen; all keys are ignored, including clear.
  - `alu_done` moves to SHOW.
  - TIMEOUT cycles without `alu_done` moves to ERR.
- SHOW:
  - Digit: clear everything and start A with that digit (ENTER_A).
  - 0xF: clear to ENTER_A.
  - Other keys: ignored.
- ERR: only 0xF exits, to ENTER_A.
- 0xF in ENTER_A, ENTER_OP, ENTER_B or ERR clears A, B, both signs, `oper` and the digit counters, and goes to ENTER_A.
- Reset values:
  - state = ENTER_A.
  - num1 = num2 = 0; bcd_a = bcd_b = 0.
  - sig1 = sig2 = 0; oper = 00.
  - start = 0; err = 0.
  - Debounce counter 0 and armed; timeout counter 0.

## Timing
- The synchronized key is available 2 cycles after the input rises.
- `acc` fires DEBOUNCE cycles later. Registers and state update on the edge following `acc`, so outputs change DEBOUNCE+3 edges after `key_valid` first goes high.
- `start`:
  - Goes high in the first EXEC cycle, exactly 1 cycle wide.
  - Is never reasserted until EXEC is re-entered.
- `alu_done`:
  - If sampled in the same cycle as `start`, it is honoured.
  - If it arrives in the same cycle as the timeout expiring, done wins (SHOW).
- A `key_valid` glitch shorter than DEBOUNCE produces no accept.
- A press held indefinitely produces one accept only.
- Asserting `btnres` at any time, including mid-EXEC, forces the reset values immediately. `start` drops asynchronously.

## Test plan
- Press 1,2,3, A, 4,5, E, each held DEBOUNCE+5 cycles, then drive `alu_done` 3 cycles after `start`.
  - Required: num1 = 123, bcd_a = 0x123, oper = 00, num2 = 45, bcd_b = 0x045.
  - Exactly one `start` pulse; state ends at SHOW.
- Press 9,9,9,7: num1 = 999, bcd_a = 0x999. Then press D, C, D, 2, E.
  - Required: sig1 = 1, oper = 10, sig2 = 1, num2 = 2.
- Pulse `key_valid` for DEBOUNCE-1 cycles with tecla = 5: no change. Then hold tecla = 5 for 10×DEBOUNCE cycles.
  - Required: num1 = 5 (a single accept).
- Press A, B, E with `alu_done` tied low.
  - Required: A = 0, oper = 01, B = 0.
  - `start` pulses once; ERR (state = 5, err = 1) is reached TIMEOUT cycles later.
  - Then press F: state = 0, all operands 0.
- Assert `btnres` low 2 cycles into EXEC.
  - Required: immediate return to all reset values; no further `start` after release.
- In SHOW, press 7.
  - Required: state = ENTER_A, num1 = 7, sig1 = 0, num2 = 0, oper = 00.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer
// Entry and execution controller for the keypad calculator. Debounces raw key
// codes, builds two signed operands of up to three decimal digits plus an
// operator, launches the arithmetic datapath with a one-cycle start, waits for
// its done (with timeout) and holds the result view until the next entry.
//
// Ports
//   clk_i        system clock (1 kHz divided clock)
//   btnres_i     asynchronous active-low reset
//   tecla_i      key code: 0-9 digit, A add, B sub, C mul, D sign, E equals, F clear
//   key_valid_i  high while a key is pressed (asynchronous)
//   alu_done_i   datapath result valid, only looked at in EXEC
//   start_o      one-cycle launch pulse
//   oper_o       00 add, 01 sub, 10 mul
//   num1_o/num2_o     operand magnitudes, 0-999
//   sig1_o/sig2_o     operand signs, 1 = negative
//   bcd_a_o/bcd_b_o   operand BCD for the display
//   state_o      current state encoding
//   err_o        high in ERR
//
// state    | meaning
// ENTER_A  | collecting operand A digits and sign
// ENTER_OP | operator latched, waiting for B or equals
// ENTER_B  | collecting operand B digits and sign
// EXEC     | start issued, waiting for alu_done or timeout
// SHOW     | result on display, waiting for next entry
// ERR      | datapath timed out, only clear exits
module calc_sequencer #(
    parameter int DEBOUNCE = 20,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        btnres_i,
    input  logic [3:0]  tecla_i,
    input  logic        key_valid_i,
    input  logic        alu_done_i,
    output logic        start_o,
    output logic [1:0]  oper_o,
    output logic [9:0]  num1_o,
    output logic [9:0]  num2_o,
    output logic        sig1_o,
    output logic        sig2_o,
    output logic [11:0] bcd_a_o,
    output logic [11:0] bcd_b_o,
    output logic [2:0]  state_o,
    output logic        err_o
);
    localparam logic [2:0] ENTER_A  = 3'd0;
    localparam logic [2:0] ENTER_OP = 3'd1;
    localparam logic [2:0] ENTER_B  = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] SHOW     = 3'd4;
    localparam logic [2:0] ERR      = 3'd5;

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]    tecla_s1_q, tecla_s2_q;
    logic          kv_s1_q, kv_s2_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          armed_q, armed_d;
    logic          acc;

    logic [2:0]    state_q, state_d;
    logic [9:0]    num1_q, num1_d, num2_q, num2_d;
    logic [11:0]   bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;
    logic          sig1_q, sig1_d, sig2_q, sig2_d;
    logic [1:0]    oper_q, oper_d;
    logic [1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic          start_q, start_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic [3:0]    key;
    logic          is_digit, is_op, do_clear, seed_a;

    // Debounce: one accept when the synchronized level has been high for
    // DEBOUNCE cycles; re-armed only by a synchronized low cycle.
    always_comb begin
        acc       = armed_q && (deb_cnt_q == DW'(DEBOUNCE));
        deb_cnt_d = deb_cnt_q;
        armed_d   = armed_q;
        if (!kv_s2_q) begin
            deb_cnt_d = '0;
            armed_d   = 1'b1;
        end else if (acc) begin
            deb_cnt_d = '0;
            armed_d   = 1'b0;
        end else if (armed_q) begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    assign key      = tecla_s2_q;
    assign is_digit = (key <= 4'd9);
    assign is_op    = (key == 4'hA) || (key == 4'hB) || (key == 4'hC);

    always_comb begin
        state_d  = state_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        bcd_a_d  = bcd_a_q;
        bcd_b_d  = bcd_b_q;
        sig1_d   = sig1_q;
        sig2_d   = sig2_q;
        oper_d   = oper_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        to_cnt_d = to_cnt_q;
        do_clear = 1'b0;
        seed_a   = 1'b0;

        case (state_q)
            ENTER_A: if (acc) begin
                if (is_digit) begin
                    if (cnt_a_q < 2'd3) begin
                        num1_d  = num1_q * 10'd10 + {6'd0, key};
                        bcd_a_d = {bcd_a_q[7:0], key};
                        cnt_a_d = cnt_a_q + 2'd1;
                    end
                end else if (is_op) begin
                    // A/B/C map to 00/01/10
                    oper_d  = key[1:0] - 2'd2;
                    state_d = ENTER_OP;
                end else if (key == 4'hD) begin
                    sig1_d = ~sig1_q;
                end else if (key == 4'hF) begin
                    do_clear = 1'b1;
                end
            end
            ENTER_OP: if (acc) begin
                if (is_digit) begin
                    num2_d  = {6'd0, key};
                    bcd_b_d = {8'd0, key};
                    cnt_b_d = 2'd1;
                    state_d = ENTER_B;
                end else if (is_op) begin
                    oper_d = key[1:0] - 2'd2;
                end else if (key == 4'hD) begin
                    sig2_d = ~sig2_q;
                end else if (key == 4'hE) begin
                    num2_d  = '0;
                    bcd_b_d = '0;
                    cnt_b_d = '0;
                    state_d = EXEC;
                end else begin
                    do_clear = 1'b1;
                end
            end
            ENTER_B: if (acc) begin
                if (is_digit) begin
                    if (cnt_b_q < 2'd3) begin
                        num2_d  = num2_q * 10'd10 + {6'd0, key};
                        bcd_b_d = {bcd_b_q[7:0], key};
                        cnt_b_d = cnt_b_q + 2'd1;
                    end
                end else if (key == 4'hD) begin
                    sig2_d = ~sig2_q;
                end else if (key == 4'hE) begin
                    state_d = EXEC;
                end else if (key == 4'hF) begin
                    do_clear = 1'b1;
                end
            end
            EXEC: begin
                // done takes priority over an expiring timeout
                if (alu_done_i) begin
                    state_d = SHOW;
                end else if (to_cnt_q <= TW'(1)) begin
                    state_d = ERR;
                end else begin
                    to_cnt_d = to_cnt_q - TW'(1);
                end
            end
            SHOW: if (acc) begin
                if (is_digit) begin
                    do_clear = 1'b1;
                    seed_a   = 1'b1;
                end else if (key == 4'hF) begin
                    do_clear = 1'b1;
                end
            end
            ERR: if (acc && key == 4'hF) begin
                do_clear = 1'b1;
            end
            default: state_d = ENTER_A;
        endcase

        if (do_clear) begin
            state_d = ENTER_A;
            num1_d  = '0;
            num2_d  = '0;
            bcd_a_d = '0;
            bcd_b_d = '0;
            sig1_d  = 1'b0;
            sig2_d  = 1'b0;
            oper_d  = 2'b00;
            cnt_a_d = '0;
            cnt_b_d = '0;
            if (seed_a) begin
                num1_d  = {6'd0, key};
                bcd_a_d = {8'd0, key};
                cnt_a_d = 2'd1;
            end
        end

        // Entering EXEC: pulse start for the first EXEC cycle and arm timeout.
        start_d = (state_d == EXEC) && (state_q != EXEC);
        if (start_d) begin
            to_cnt_d = TW'(TIMEOUT);
        end
    end

    always_ff @(posedge clk_i or negedge btnres_i) begin
        if (!btnres_i) begin
            tecla_s1_q <= '0;
            tecla_s2_q <= '0;
            kv_s1_q    <= 1'b0;
            kv_s2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            armed_q    <= 1'b1;
            state_q    <= ENTER_A;
            num1_q     <= '0;
            num2_q     <= '0;
            bcd_a_q    <= '0;
            bcd_b_q    <= '0;
            sig1_q     <= 1'b0;
            sig2_q     <= 1'b0;
            oper_q     <= 2'b00;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            start_q    <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            tecla_s1_q <= tecla_i;
            tecla_s2_q <= tecla_s1_q;
            kv_s1_q    <= key_valid_i;
            kv_s2_q    <= kv_s1_q;
            deb_cnt_q  <= deb_cnt_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            bcd_a_q    <= bcd_a_d;
            bcd_b_q    <= bcd_b_d;
            sig1_q     <= sig1_d;
            sig2_q     <= sig2_d;
            oper_q     <= oper_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            start_q    <= start_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign start_o = start_q;
    assign oper_o  = oper_q;
    assign num1_o  = num1_q;
    assign num2_o  = num2_q;
    assign sig1_o  = sig1_q;
    assign sig2_o  = sig2_q;
    assign bcd_a_o = bcd_a_q;
    assign bcd_b_o = bcd_b_q;
    assign state_o = state_q;
    assign err_o   = (state_q == ERR);

endmodule
